fpga_control_pio_irq: RTL and testbench
=======================================

# fpga_control_pio_irq

Parametrised Avalon-MM input port that replaces the single-bit, poll-only control input on the HPS lightweight bridge. It synchronises a WIDTH-bit control bus from the FPGA fabric, captures selected edges per bit into sticky write-1-to-clear flags, and raises a maskable interrupt to the HPS. Software can therefore react to AES start/abort controls without polling.

## Interface
- WIDTH, 8: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser depth, 2..4.
- EDGE_TYPE, 0: edge captured on each bit; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: debounce window in clocks, 1..65535. Used only when debounce is compiled in.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  qualifies write.
- write  in  1  write strobe; acted on only when chipselect=1.
- writedata  in  32  write data; bits above WIDTH are ignored.
- in_port  in  WIDTH  asynchronous control inputs.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt, high while any unmasked capture flag is set.

## Operation
Register map:
- Address 0 is DATA (read-only): the filtered input value.
- Address 1 is PENDING (read-only): edgecapture & irqmask.
- Address 2 is IRQMASK (read/write): a write loads writedata[WIDTH-1:0].
- Address 3 is EDGECAPTURE (read/write-1-to-clear): each bit whose writedata bit is 1 is cleared.
- Writes to address 0 or 1 are ignored.

Datapath:
- in_port passes through a per-bit SYNC_STAGES flop chain; its output is sync.
- filt is sync, or the debounced sync when debounce is compiled in.
- prev is filt delayed by one clock.
- edge[i] is the rising term (filt & ~prev), the falling term (~filt & prev), or either, per EDGE_TYPE.

Start-up guard:
- After reset deasserts, a counter suppresses edge capture for SYNC_STAGES+1 clocks.
- This prevents a spurious capture while the chain fills, e.g. in_port high during reset.

Capture and interrupt:
- edgecapture[i] is set on edge[i]. It stays set until cleared by a write-1.
- If edge[i] and a clear of bit i occur in the same cycle, set wins and the edge is not lost.
- irq = |(edgecapture & irqmask). It is combinational from registers, so it has no glitch path from in_port.

Read path:
- readdata is loaded every clock from the register selected by address, independent of chipselect and read.

## Timing
- Reset values: sync chain, prev, filt, edgecapture, irqmask, readdata and the guard counter are all 0; irq is 0.
- Read latency is 1 clock: address presented before edge N gives readdata valid after edge N.
- Without debounce: in_port stable before edge N gives sync updated at edge N+SYNC_STAGES-1. The edgecapture bit and irq update at edge N+SYNC_STAGES. readdata at address 0 shows the new value after edge N+SYNC_STAGES.
- IRQMASK write at edge N: irq reflects the new mask after edge N.
- EDGECAPTURE clear at edge N: the bit reads 0, and irq deasserts if no other flag is pending, after edge N.
- Reset asserted mid-operation clears everything immediately. The start-up guard re-arms on release.
- Input pulses shorter than one clock period may be missed; no capture is guaranteed for them.

## Configuration
Macro: FPGA_CONTROL_DEBOUNCE_EN.

Defined:
- Each bit has a 16-bit counter.
- While sync[i] differs from filt[i], the counter increments; otherwise it resets to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, filt[i] takes sync[i] and the counter resets.
- Net effect: a change must persist for DEBOUNCE_CYCLES consecutive clocks, adding DEBOUNCE_CYCLES clocks of latency.

Undefined:
- filt = sync.
- No counters are built and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, then read addresses 0..3: all return 0x00000000 and irq=0. Also hold in_port=0xFF through reset release: no capture, EDGECAPTURE reads 0.
- WIDTH=8, EDGE_TYPE=0, IRQMASK=0x01, in_port 0x00→0x05: EDGECAPTURE=0x05 and PENDING=0x01 exactly SYNC_STAGES+1 clocks later; irq=1.
- Write 0x01 to address 3: EDGECAPTURE=0x04 and irq=0 next clock. Write 0x04 in the same cycle as a new rising edge on bit 2: bit 2 stays set.
- EDGE_TYPE=2, in_port toggles bit 7 0→1→0 with 10 clocks per level: bit 7 captured, cleared, and captured again. IRQMASK=0x00 keeps irq=0 throughout.
- Debounce build, DEBOUNCE_CYCLES=16: a 15-clock glitch on bit 0 gives no DATA change and no capture. A 16-clock level gives DATA bit 0=1 after SYNC_STAGES+16 clocks, with capture.
- Assert reset with EDGECAPTURE=0xFF and IRQMASK=0xFF: irq drops immediately and all registers read 0 after release.

Source files
------------

// File: rtl/fpga_control_pio_irq.sv
// fpga_control_pio_irq
//
// Avalon-MM parallel input port with per-bit edge capture and a maskable
// level interrupt. A WIDTH-bit control bus from the fabric is synchronised.
// It is optionally debounced, and the selected edges are captured into sticky
// write-1-to-clear flags.
//
// Optional feature: define FPGA_CONTROL_DEBOUNCE_EN to build a per-bit
// debounce filter. A change must then persist for DEBOUNCE_CYCLES clocks.
// Without it, the filtered value is the synchroniser output.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   address     register select: 0 DATA, 1 PENDING, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect  qualifies write
//   write       write strobe
//   writedata   write data, bits above WIDTH ignored
//   in_port     asynchronous control inputs
//   readdata    registered read data, one clock latency, upper bits zero
//   irq         high while any unmasked capture flag is set

module fpga_control_pio_irq #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned GuardW = $clog2(SYNC_STAGES + 2);
  localparam logic [GuardW-1:0] GuardDone = GuardW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] wr_clear;
  logic [GuardW-1:0] guard_q, guard_d;
  logic             capture_en;
  logic [31:0]      readdata_d;
  logic             unused_wdata;

  // Only writedata[WIDTH-1:0] is meaningful.
  assign unused_wdata = ^writedata;

  // Synchroniser: stage 0 samples in_port, the last stage is sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef FPGA_CONTROL_DEBOUNCE_EN
  localparam logic [15:0] DbLast = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][15:0] db_cnt_q, db_cnt_d;
  logic [WIDTH-1:0]       filt_q, filt_d;

  // Counter runs only while sync disagrees with filt. It resets on agreement,
  // so a glitch shorter than the window leaves filt unchanged.
  always_comb begin
    db_cnt_d = db_cnt_q;
    filt_d   = filt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          filt_d[i]   = sync[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= '0;
      filt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^32'(DEBOUNCE_CYCLES);
  assign filt = sync;
`endif

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = filt & ~prev_q;
      1:       edge_det = ~filt & prev_q;
      default: edge_det = filt ^ prev_q;
    endcase
  end

  // Start-up guard: no capture until the synchroniser has refilled after
  // reset. This stops an input held high through reset from looking like an edge.
  assign capture_en = (guard_q == GuardDone);
  assign guard_d    = capture_en ? guard_q : guard_q + 1'b1;

  always_comb begin
    irqmask_d = irqmask_q;
    wr_clear  = '0;
    if (chipselect && write) begin
      case (address)
        2'd2:    irqmask_d = writedata[WIDTH-1:0];
        2'd3:    wr_clear  = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    // Set after clear, so a coincident edge is never lost.
    edgecap_d = (edgecap_q & ~wr_clear) | (edge_det & {WIDTH{capture_en}});
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0: readdata_d[WIDTH-1:0] = filt;
      2'd1: readdata_d[WIDTH-1:0] = edgecap_q & irqmask_q;
      2'd2: readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3: readdata_d[WIDTH-1:0] = edgecap_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      edgecap_q <= '0;
      irqmask_q <= '0;
      guard_q   <= '0;
      readdata  <= '0;
    end else begin
      prev_q    <= filt;
      edgecap_q <= edgecap_d;
      irqmask_q <= irqmask_d;
      guard_q   <= guard_d;
      readdata  <= readdata_d;
    end
  end

  // Purely from registers, so no combinational path from in_port.
  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_fpga_control_pio_irq.sv
// Bench for fpga_control_pio_irq: two instances (rising-edge and any-edge)
// share one bus. A cycle-level reference model built from the register-map
// and latency rules predicts readdata and irq after every clock.

module tb_fpga_control_pio_irq;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd0, rd2;
  logic          irq0, irq2;

  fpga_control_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  fpga_control_pio_irq #(
    .WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)
  ) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, meaning "as seen after the most recent edge".
  logic [W-1:0]  m_sync, m_filt, m_prev, m_mask, m_ec0, m_ec2;
  logic [31:0]   m_rd0, m_rd2;
  int            m_k;
  logic [W-1:0]  in_hist[$];
  logic [W-1:0]  sync_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sel(input logic [1:0] a, input logic [W-1:0] ec);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[W-1:0] = m_filt;
      2'd1:    r[W-1:0] = ec & m_mask;
      2'd2:    r[W-1:0] = m_mask;
      default: r[W-1:0] = ec;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_sync = '0; m_filt = '0; m_prev = '0; m_mask = '0; m_ec0 = '0; m_ec2 = '0;
    m_rd0 = '0; m_rd2 = '0; m_k = 0;
    in_hist = {};
    sync_hist = {};
    for (int i = 0; i < SS; i++) in_hist.push_back('0);
    for (int i = 0; i < DC; i++) sync_hist.push_back('0);
  endtask

  // Predict the effect of the next rising edge, take it, then compare.
  task automatic step();
    logic [31:0]  nrd0, nrd2;
    logic [W-1:0] en, rise, fall, clr, nsync, nfilt;
    m_k++;
    nrd0 = sel(address, m_ec0);
    nrd2 = sel(address, m_ec2);
    en   = (m_k >= SS + 2) ? '1 : '0;
    rise = m_filt & ~m_prev & en;
    fall = ~m_filt & m_prev & en;
    clr  = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ec0 = (m_ec0 & ~clr) | rise;
    m_ec2 = (m_ec2 & ~clr) | rise | fall;
    if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
    in_hist.push_back(in_port);
    void'(in_hist.pop_front());
    nsync = in_hist[0];
`ifdef FPGA_CONTROL_DEBOUNCE_EN
    // filt follows a value only once sync held it for the last DC samples.
    nfilt = m_filt;
    for (int i = 0; i < W; i++) begin
      logic ok;
      ok = (m_sync[i] != m_filt[i]);
      foreach (sync_hist[j]) if (sync_hist[j][i] != m_sync[i]) ok = 1'b0;
      if (ok) nfilt[i] = m_sync[i];
    end
    sync_hist.push_back(nsync);
    void'(sync_hist.pop_front());
`else
    nfilt = nsync;
`endif
    m_prev = m_filt;
    m_filt = nfilt;
    m_sync = nsync;
    @(posedge clk);
    #1;
    m_rd0 = nrd0;
    m_rd2 = nrd2;
    check("rd_rise", rd0, m_rd0);
    check("rd_any", rd2, m_rd2);
    check("irq_rise", {31'b0, irq0}, {31'b0, |(m_ec0 & m_mask)});
    check("irq_any", {31'b0, irq2}, {31'b0, |(m_ec2 & m_mask)});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    model_reset();
    in_port = '1;
    #1;
    check("rst_rd", rd0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // In_port high through reset release: no capture.
    for (int i = 0; i < 8; i++) begin
      address = 2'(i);
      step();
    end
    address = 2'd3;
    step();
    check("no_capture_at_start", rd0, 32'h0);

    // Rising edges on bits 0 and 2 with mask 0x01.
    in_port = '0;
    repeat (SS + 3) step();
    wr_reg(2'd2, 32'h01);
    address = 2'd3;
    in_port = 8'h05;
    repeat (SS + 1) step();
    check("irq_after_edge", {31'b0, irq0}, 32'h1);
    step();
    check("ec_05", rd0, 32'h05);
    address = 2'd1;
    step();
    check("pending_01", rd0, 32'h01);

    // Write-1-to-clear of bit 0.
    wr_reg(2'd3, 32'h01);
    check("irq_cleared", {31'b0, irq0}, 32'h0);
    address = 2'd3;
    step();
    check("ec_04", rd0, 32'h04);

    // New edge on bit 2 coincides with its clear: set wins.
    in_port = 8'h01;
    repeat (SS + 3) step();
    in_port = 8'h05;
    repeat (SS) step();
    wr_reg(2'd3, 32'h04);
    address = 2'd3;
    step();
    check("set_wins", rd0, 32'h04);

    // Bit 7 toggle with mask 0: any-edge captures both, rising only the first.
    wr_reg(2'd2, 32'h00);
    wr_reg(2'd3, 32'hFF);
    address = 2'd3;
    in_port = 8'h85;
    repeat (10) step();
    check("any_rise7", rd2 & 32'h80, 32'h80);
    wr_reg(2'd3, 32'h80);
    address = 2'd3;
    step();
    check("any_clr7", rd2 & 32'h80, 32'h0);
    in_port = 8'h05;
    repeat (10) step();
    check("any_fall7", rd2 & 32'h80, 32'h80);
    check("rise_no_fall7", rd0 & 32'h80, 32'h0);
    check("irq_masked", {31'b0, irq2}, 32'h0);

`ifdef FPGA_CONTROL_DEBOUNCE_EN
    // 15-clock glitch rejected, 16-clock level accepted.
    in_port = '0;
    repeat (DC + SS + 4) step();
    wr_reg(2'd3, 32'hFF);
    address = 2'd0;
    in_port = 8'h01;
    repeat (DC - 1) step();
    in_port = '0;
    repeat (DC + SS + 4) step();
    check("glitch_data", rd0, 32'h0);
    address = 2'd3;
    step();
    check("glitch_ec", rd0, 32'h0);
    address = 2'd0;
    in_port = 8'h01;
    repeat (DC + SS + 2) step();
    check("debounced_data", rd0, 32'h01);
`endif

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) in_port = W'($urandom);
      address = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) wr_reg(2'($urandom_range(3)), $urandom);
      else step();
    end

    // Reset with every flag set and unmasked.
    in_port = '0;
    repeat (DC + SS + 4) step();
    wr_reg(2'd2, 32'hFF);
    wr_reg(2'd3, 32'hFF);
    in_port = '1;
    repeat (DC + SS + 4) step();
    check("all_pending_irq", {31'b0, irq0}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid_irq0", {31'b0, irq0}, 32'h0);
    check("rst_mid_irq2", {31'b0, irq2}, 32'h0);
    check("rst_mid_rd", rd0, 32'h0);
    in_port = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      step();
      check("post_rst_rd", rd0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
